// File: rtl/button_event_arbiter.sv
// button_event_arbiter: per-channel synchronizer + debounced rising-edge
// detector, merged into one valid/ready event stream by a round-robin arbiter.
`timescale 1ns/1ps
module button_event_arbiter #(
   parameter int NUM_BTN        = 4,
   parameter int LOCKOUT_CYCLES = 15_000_000,
   parameter int SYNC_STAGES    = 2
) (
   input  logic                       clk_in,
   input  logic                       rst_n_in,
   input  logic [NUM_BTN-1:0]         btn_in,
   input  logic                       evt_ready_in,
   input  logic                       clear_overflow_in,
   output logic                       evt_valid_out,
   output logic [$clog2(NUM_BTN)-1:0] evt_id_out,
   output logic [NUM_BTN-1:0]         busy_out,
   output logic                       evt_overflow_out
);

   localparam int ID_W  = $clog2(NUM_BTN);
   localparam int CNT_W = $clog2(LOCKOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCKOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [ID_W-1:0]  RR_INIT  = ID_W'(NUM_BTN - 1);

   typedef enum logic {IDLE, LOCK} ch_state_t;

   logic [NUM_BTN-1:0] sync_q [SYNC_STAGES];
   logic [NUM_BTN-1:0] sync_d [SYNC_STAGES];
   ch_state_t          state_q [NUM_BTN];
   ch_state_t          state_d [NUM_BTN];
   logic [CNT_W-1:0]   cnt_q [NUM_BTN];
   logic [CNT_W-1:0]   cnt_d [NUM_BTN];
   logic [NUM_BTN-1:0] prev_q, prev_d;
   logic [NUM_BTN-1:0] pend_q, pend_d;
   logic [NUM_BTN-1:0] busy_q, busy_d;
   logic [NUM_BTN-1:0] rise, grant;
   logic               valid_q, valid_d;
   logic               ovf_q, ovf_d;
   logic [ID_W-1:0]    id_q, id_d;
   logic [ID_W-1:0]    rr_q, rr_d;
   logic [ID_W-1:0]    gnt_idx;
   logic               free, found;

   // Channel index "step" positions after base, wrapping at NUM_BTN.
   function automatic logic [ID_W-1:0] rr_idx(input logic [ID_W-1:0] base, input int step);
      return ID_W'((int'(base) + step) % NUM_BTN);
   endfunction

   // Synchronizer shift chain, one column per channel.
   always_comb begin
      sync_d[0] = btn_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_d[s] = sync_q[s-1];
   end

   // Per-channel edge detect and lockout FSM; prev is forced high in LOCK so a
   // level still held at the end of lockout needs a low before it can retrigger.
   always_comb begin
      for (int i = 0; i < NUM_BTN; i++) begin
         rise[i]    = 1'b0;
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         prev_d[i]  = prev_q[i];
         case (state_q[i])
            IDLE: begin
               if (sync_q[SYNC_STAGES-1][i] && !prev_q[i]) begin
                  rise[i]    = 1'b1;
                  state_d[i] = LOCK;
                  cnt_d[i]   = CNT_ONE;
               end else begin
                  prev_d[i] = sync_q[SYNC_STAGES-1][i];
               end
            end
            default: begin
               prev_d[i] = 1'b1;
               if (cnt_q[i] == CNT_LAST) begin
                  cnt_d[i]   = '0;
                  state_d[i] = IDLE;
               end else begin
                  cnt_d[i] = cnt_q[i] + CNT_ONE;
               end
            end
         endcase
         busy_d[i] = (state_d[i] == LOCK);
      end
   end

   // Round-robin grant into the output register, pending bits and sticky overflow.
   always_comb begin
      free    = !valid_q || evt_ready_in;
      found   = 1'b0;
      gnt_idx = rr_q;
      for (int k = 1; k <= NUM_BTN; k++) begin
         if (!found && pend_q[rr_idx(rr_q, k)]) begin
            found   = 1'b1;
            gnt_idx = rr_idx(rr_q, k);
         end
      end
      grant = '0;
      if (free && found) grant[gnt_idx] = 1'b1;
      // A rise landing on the cycle its own pending bit is granted re-arms it cleanly.
      pend_d  = (pend_q & ~grant) | rise;
      ovf_d   = (|(rise & pend_q & ~grant)) | (ovf_q & ~clear_overflow_in);
      valid_d = valid_q;
      id_d    = id_q;
      rr_d    = rr_q;
      if (free) begin
         if (found) begin
            valid_d = 1'b1;
            id_d    = gnt_idx;
            rr_d    = gnt_idx;
         end else begin
            valid_d = 1'b0;
         end
      end
   end

   // State registers; RR pointer resets to the last channel so channel 0 wins first.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
         for (int i = 0; i < NUM_BTN; i++) begin
            state_q[i] <= IDLE;
            cnt_q[i]   <= '0;
         end
         prev_q  <= '0;
         pend_q  <= '0;
         busy_q  <= '0;
         valid_q <= 1'b0;
         ovf_q   <= 1'b0;
         id_q    <= '0;
         rr_q    <= RR_INIT;
      end else begin
         for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= sync_d[s];
         for (int i = 0; i < NUM_BTN; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
         prev_q  <= prev_d;
         pend_q  <= pend_d;
         busy_q  <= busy_d;
         valid_q <= valid_d;
         ovf_q   <= ovf_d;
         id_q    <= id_d;
         rr_q    <= rr_d;
      end
   end

   assign evt_valid_out    = valid_q;
   assign evt_id_out       = id_q;
   assign busy_out         = busy_q;
   assign evt_overflow_out = ovf_q;

endmodule
